keypad_note_tracker: RTL and testbench

Consumes the priority-encoded keypad stream ({keycode, strobe} plus octave_key_up/octave_key_down levels) and turns it into discrete note press/release events.
- Filters the stream for stability.
- Tracks the single held key and the current octave.
- Hands events downstream over a valid/ready handshake to the voice/oscillator logic.
- Sits directly after the keypad encoder.

---
 rtl/keypad_note_tracker.sv | 244 ++++++++++++++++++++++++
 tb/tb_keypad_note_tracker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_note_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_note_tracker
//  Description : Turns the priority-encoded keypad stream into discrete note
//                press/release events for the voice/oscillator logic.
//                - Filters {keycode, strobe} for stability.
//                - Tracks the single held key and the current octave.
//                - Presents events on a one-entry valid/ready slot.
//
//  Ports
//    clk              system clock
//    rst              synchronous active-high reset
//    keycode[4:0]     encoded key index from keypad encoder
//    strobe           1 = a key is pressed (keycode valid)
//    octave_key_up    synchronized level, octave up button
//    octave_key_down  synchronized level, octave down button
//    evt_ready        downstream accepts the event this cycle
//    evt_valid        event slot occupied
//    evt_press        1 = press event, 0 = release event
//    evt_note[6:0]    note number = octave*12 + keycode
//    octave[2:0]      current octave
//    key_held         1 while a press has been emitted without its release
//
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_note_tracker #(
    parameter int STABLE_CYCLES  = 4,
    parameter int NUM_KEYS       = 17,
    parameter int DEFAULT_OCTAVE = 4,
    parameter int MAX_OCTAVE     = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] keycode,
    input  logic       strobe,
    input  logic       octave_key_up,
    input  logic       octave_key_down,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic       evt_press,
    output logic [6:0] evt_note,
    output logic [2:0] octave,
    output logic       key_held
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The counter holds "edges seen with this sample, minus one", so it only
    // needs to reach STABLE_CYCLES-1.
    localparam int               CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]       OCT_MAX = 3'(MAX_OCTAVE);
    localparam logic [2:0]       OCT_RST = 3'(DEFAULT_OCTAVE);
    localparam logic [6:0]       SEMIS   = 7'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_SWAP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Candidate: "no key" is carried as vld=0 with the key field forced to 0
    // so that every "no key" flavour (strobe low, out-of-range code) compares
    // equal in the stability filter.
    // ------------------------------------------------------------------------
    logic       cand_vld;
    logic [4:0] cand_key;

    always_comb begin
        cand_vld = strobe && (int'(keycode) < NUM_KEYS);
        cand_key = cand_vld ? keycode : 5'd0;
    end

    // ------------------------------------------------------------------------
    // Stability filter
    // ------------------------------------------------------------------------
    logic             samp_vld_q, samp_vld_d;
    logic [4:0]       samp_key_q, samp_key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_vld_q, acc_vld_d;
    logic [4:0]       acc_key_q, acc_key_d;
    logic             same_sample;

    always_comb begin
        same_sample = (cand_vld == samp_vld_q) && (cand_key == samp_key_q);
        samp_vld_d  = cand_vld;
        samp_key_d  = cand_key;
        if (!same_sample) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Accept on the edge that completes STABLE_CYCLES identical samples;
        // re-accepting the same value on later edges is harmless.
        if (cnt_d == CNT_MAX) begin
            acc_vld_d = cand_vld;
            acc_key_d = cand_key;
        end else begin
            acc_vld_d = acc_vld_q;
            acc_key_d = acc_key_q;
        end
    end

    // ------------------------------------------------------------------------
    // Octave up/down with rising-edge detect and saturation
    // ------------------------------------------------------------------------
    logic       up_q, dn_q;
    logic [2:0] oct_q, oct_d;
    logic       up_rise, dn_rise;

    always_comb begin
        up_rise = octave_key_up & ~up_q;
        dn_rise = octave_key_down & ~dn_q;
        oct_d   = oct_q;
        if (up_rise && !dn_rise && (oct_q < OCT_MAX)) begin
            oct_d = oct_q + 3'd1;
        end else if (dn_rise && !up_rise && (oct_q != 3'd0)) begin
            oct_d = oct_q - 3'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Note FSM and event slot
    // ------------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [4:0] held_key_q, held_key_d;
    logic [6:0] held_note_q, held_note_d;
    logic       evt_valid_q, evt_valid_d;
    logic       evt_press_q, evt_press_d;
    logic [6:0] evt_note_q, evt_note_d;
    logic       slot_free;
    logic [6:0] press_note;

    always_comb begin
        state_d     = state_q;
        held_key_d  = held_key_q;
        held_note_d = held_note_q;
        // A consumed event empties the slot unless reloaded below; press and
        // note keep their last values so a stalled event stays stable.
        evt_valid_d = evt_valid_q & ~evt_ready;
        evt_press_d = evt_press_q;
        evt_note_d  = evt_note_q;
        slot_free   = ~evt_valid_q | evt_ready;
        press_note  = (7'(oct_q) * SEMIS) + 7'(acc_key_q);

        if (slot_free) begin
            case (state_q)
                ST_IDLE: begin
                    if (acc_vld_q) begin
                        evt_valid_d = 1'b1;
                        evt_press_d = 1'b1;
                        evt_note_d  = press_note;
                        held_key_d  = acc_key_q;
                        held_note_d = press_note;
                        state_d     = ST_HELD;
                    end
                end
                ST_HELD: begin
                    // Release always reports the latched note, so an octave
                    // change during the hold cannot orphan a voice.
                    if (!acc_vld_q) begin
                        evt_valid_d = 1'b1;
                        evt_press_d = 1'b0;
                        evt_note_d  = held_note_q;
                        state_d     = ST_IDLE;
                    end else if (acc_key_q != held_key_q) begin
                        evt_valid_d = 1'b1;
                        evt_press_d = 1'b0;
                        evt_note_d  = held_note_q;
                        state_d     = ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    // The key may have gone away while the release waited.
                    if (acc_vld_q) begin
                        evt_valid_d = 1'b1;
                        evt_press_d = 1'b1;
                        evt_note_d  = press_note;
                        held_key_d  = acc_key_q;
                        held_note_d = press_note;
                        state_d     = ST_HELD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_vld_q  <= 1'b0;
            samp_key_q  <= 5'd0;
            cnt_q       <= '0;
            acc_vld_q   <= 1'b0;
            acc_key_q   <= 5'd0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            oct_q       <= OCT_RST;
            state_q     <= ST_IDLE;
            held_key_q  <= 5'd0;
            held_note_q <= 7'd0;
            evt_valid_q <= 1'b0;
            evt_press_q <= 1'b0;
            evt_note_q  <= 7'd0;
        end else begin
            samp_vld_q  <= samp_vld_d;
            samp_key_q  <= samp_key_d;
            cnt_q       <= cnt_d;
            acc_vld_q   <= acc_vld_d;
            acc_key_q   <= acc_key_d;
            up_q        <= octave_key_up;
            dn_q        <= octave_key_down;
            oct_q       <= oct_d;
            state_q     <= state_d;
            held_key_q  <= held_key_d;
            held_note_q <= held_note_d;
            evt_valid_q <= evt_valid_d;
            evt_press_q <= evt_press_d;
            evt_note_q  <= evt_note_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign evt_valid = evt_valid_q;
    assign evt_press = evt_press_q;
    assign evt_note  = evt_note_q;
    assign octave    = oct_q;
    assign key_held  = (state_q == ST_HELD);

endmodule
`default_nettype wire

// File: tb/tb_keypad_note_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_note_tracker
//  Description : Directed, table-driven bench for keypad_note_tracker with
//                hand-written sequences for stalled-slot and reset cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_note_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] keycode;
    logic       strobe;
    logic       octave_key_up;
    logic       octave_key_down;
    logic       evt_ready;
    logic       evt_valid;
    logic       evt_press;
    logic [6:0] evt_note;
    logic [2:0] octave;
    logic       key_held;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    keypad_note_tracker #(
        .STABLE_CYCLES  (4),
        .NUM_KEYS       (17),
        .DEFAULT_OCTAVE (4),
        .MAX_OCTAVE     (7)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .keycode         (keycode),
        .strobe          (strobe),
        .octave_key_up   (octave_key_up),
        .octave_key_down (octave_key_down),
        .evt_ready       (evt_ready),
        .evt_valid       (evt_valid),
        .evt_press       (evt_press),
        .evt_note        (evt_note),
        .octave          (octave),
        .key_held        (key_held)
    );

    // One record = inputs held across one rising edge, and outputs expected
    // just after that edge. press/note are only checked when valid is expected.
    typedef struct packed {
        logic [8*10-1:0] nm;
        logic            r;
        logic            s;
        logic [4:0]      k;
        logic            u;
        logic            d;
        logic            rd;
        logic            ev;
        logic            pr;
        logic [6:0]      nt;
        logic [2:0]      oc;
        logic            kh;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [8*10-1:0] nm, input logic r, input logic s,
                       input logic [4:0] k, input logic u, input logic d,
                       input logic rd, input logic ev, input logic pr,
                       input logic [6:0] nt, input logic [2:0] oc,
                       input logic kh, input int n);
        vec_t v;
        v.nm = nm; v.r = r; v.s = s; v.k = k; v.u = u; v.d = d; v.rd = rd;
        v.ev = ev; v.pr = pr; v.nt = nt; v.oc = oc; v.kh = kh;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic [4:0] k,
                         input logic u, input logic d, input logic rd);
        rst = r; strobe = s; keycode = k;
        octave_key_up = u; octave_key_down = d; evt_ready = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [8*10-1:0] nm, input logic ev, input logic pr,
                       input logic [6:0] nt, input logic [2:0] oc, input logic kh);
        logic ok;
        ok = (evt_valid === ev) && (octave === oc) && (key_held === kh);
        if (ev) ok = ok && (evt_press === pr) && (evt_note === nt);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %0s @%0t: got valid=%b press=%b note=%0d octave=%0d held=%b, want valid=%b press=%b note=%0d octave=%0d held=%b",
                     nm, $time, evt_valid, evt_press, evt_note, octave, key_held,
                     ev, pr, nt, oc, kh);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // ---- basic press/release of key 9 at octave 4 ----
        add("t1_rst",    1,0, 5'd9, 0,0,1, 0,0, 7'd0,   3'd4, 0, 2);
        add("t1_fill",   0,1, 5'd9, 0,0,1, 0,0, 7'd0,   3'd4, 0, 4);
        add("t1_press",  0,1, 5'd9, 0,0,1, 1,1, 7'd57,  3'd4, 1, 1);
        add("t1_hold",   0,1, 5'd9, 0,0,1, 0,0, 7'd0,   3'd4, 1, 4);
        add("t1_rfill",  0,0, 5'd0, 0,0,1, 0,0, 7'd0,   3'd4, 1, 4);
        add("t1_rel",    0,0, 5'd0, 0,0,1, 1,0, 7'd57,  3'd4, 0, 1);
        add("t1_idle",   0,0, 5'd0, 0,0,1, 0,0, 7'd0,   3'd4, 0, 3);
        // ---- short excursion and out-of-range code ----
        add("t2_short",  0,1, 5'd3, 0,0,1, 0,0, 7'd0,   3'd4, 0, 3);
        add("t2_gap",    0,0, 5'd0, 0,0,1, 0,0, 7'd0,   3'd4, 0, 6);
        add("t2_code20", 0,1, 5'd20,0,0,1, 0,0, 7'd0,   3'd4, 0, 10);
        add("t2_gap2",   0,0, 5'd0, 0,0,1, 0,0, 7'd0,   3'd4, 0, 2);
        // ---- octave stepping, saturation, latched release note ----
        add("t4_uphold", 0,0, 5'd0, 1,0,1, 0,0, 7'd0,   3'd5, 0, 20);
        add("t4_up0",    0,0, 5'd0, 0,0,1, 0,0, 7'd0,   3'd5, 0, 1);
        add("t4_up6",    0,0, 5'd0, 1,0,1, 0,0, 7'd0,   3'd6, 0, 1);
        add("t4_up0",    0,0, 5'd0, 0,0,1, 0,0, 7'd0,   3'd6, 0, 1);
        add("t4_up7",    0,0, 5'd0, 1,0,1, 0,0, 7'd0,   3'd7, 0, 1);
        add("t4_up0",    0,0, 5'd0, 0,0,1, 0,0, 7'd0,   3'd7, 0, 1);
        add("t4_upsat",  0,0, 5'd0, 1,0,1, 0,0, 7'd0,   3'd7, 0, 1);
        add("t4_up0",    0,0, 5'd0, 0,0,1, 0,0, 7'd0,   3'd7, 0, 1);
        add("t4_k16f",   0,1, 5'd16,0,0,1, 0,0, 7'd0,   3'd7, 0, 4);
        add("t4_k16p",   0,1, 5'd16,0,0,1, 1,1, 7'd100, 3'd7, 1, 1);
        add("t4_dn",     0,1, 5'd16,0,1,1, 0,0, 7'd0,   3'd6, 1, 1);
        add("t4_dn0",    0,1, 5'd16,0,0,1, 0,0, 7'd0,   3'd6, 1, 2);
        add("t4_relf",   0,0, 5'd0, 0,0,1, 0,0, 7'd0,   3'd6, 1, 4);
        add("t4_rel100", 0,0, 5'd0, 0,0,1, 1,0, 7'd100, 3'd6, 0, 1);
        add("t4_both",   0,0, 5'd0, 1,1,1, 0,0, 7'd0,   3'd6, 0, 1);
        add("t4_both0",  0,0, 5'd0, 0,0,1, 0,0, 7'd0,   3'd6, 0, 1);
        for (int i = 0; i < 7; i++) begin
            add("t4_dnp",  0,0, 5'd0, 0,1,1, 0,0, 7'd0, (i < 6) ? 3'(5 - i) : 3'd0, 0, 1);
            add("t4_dnp0", 0,0, 5'd0, 0,0,1, 0,0, 7'd0, (i < 6) ? 3'(5 - i) : 3'd0, 0, 1);
        end
        // ---- direct key swap with ready high ----
        add("t5_rst",    1,0, 5'd0, 0,0,1, 0,0, 7'd0,   3'd4, 0, 1);
        add("t5_f0",     0,1, 5'd0, 0,0,1, 0,0, 7'd0,   3'd4, 0, 4);
        add("t5_p48",    0,1, 5'd0, 0,0,1, 1,1, 7'd48,  3'd4, 1, 1);
        add("t5_h0",     0,1, 5'd0, 0,0,1, 0,0, 7'd0,   3'd4, 1, 2);
        add("t5_f5",     0,1, 5'd5, 0,0,1, 0,0, 7'd0,   3'd4, 1, 4);
        add("t5_r48",    0,1, 5'd5, 0,0,1, 1,0, 7'd48,  3'd4, 0, 1);
        add("t5_p53",    0,1, 5'd5, 0,0,1, 1,1, 7'd53,  3'd4, 1, 1);
        add("t5_h5",     0,1, 5'd5, 0,0,1, 0,0, 7'd0,   3'd4, 1, 2);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].r, vq[i].s, vq[i].k, vq[i].u, vq[i].d, vq[i].rd);
            tick();
            chk(vq[i].nm, vq[i].ev, vq[i].pr, vq[i].nt, vq[i].oc, vq[i].kh);
        end

        // ---- stalled slot: key changes and release while ready is low ----
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t3_rst", 1'b0, 1'b0, 7'd0, 3'd4, 1'b0);
        drive(1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        tick();
        chk("t3_press", 1'b1, 1'b1, 7'd50, 3'd4, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i < 4)       drive(1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
            else if (i < 10) drive(1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
            else             drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            tick();
            chk("t3_stall", 1'b1, 1'b1, 7'd50, 3'd4, 1'b1);
        end
        drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("t3_rel50", 1'b1, 1'b0, 7'd50, 3'd4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_nop51", 1'b0, 1'b0, 7'd0, 3'd4, 1'b0);
        end

        // ---- reset while a press is stalled in the slot ----
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        tick();
        chk("t6_press", 1'b1, 1'b1, 7'd55, 3'd4, 1'b1);
        tick();
        chk("t6_stall", 1'b1, 1'b1, 7'd55, 3'd4, 1'b1);
        drive(1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t6_rst", 1'b0, 1'b0, 7'd0, 3'd4, 1'b0);
        drive(1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_norel", 1'b0, 1'b0, 7'd0, 3'd4, 1'b0);
        end
        tick();
        chk("t6_repress", 1'b1, 1'b1, 7'd55, 3'd4, 1'b1);
        tick();
        chk("t6_after", 1'b0, 1'b0, 7'd0, 3'd4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
